// File: rtl/id_ex_latch.sv
// ---------------------------------------------------------------------------
// id_ex_latch
//   ID/EX pipeline register. Captures register-file read data, the immediate,
//   register specifiers and decoded control from ID each cycle. Inserts a
//   bubble on stall or flush, and freezes completely under debug halt.
//   Exposes a combinational debug readout and a saturating bubble counter.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   halt                    debug freeze: all state held, stall/flush ignored
//   stall, flush            bubble requests (control cleared, valid dropped)
//   id_*                    ID-stage fields to be latched
//   wb_reg_addr/_write_data/_write_enable
//                           WB-stage register-file write port
//   ex_*                    latched EX-stage fields, ex_valid = real instruction
//   du_sel, du_data         debug field select and combinational readout
//
// Build option
//   ID_EX_WB_BYPASS_EN      when defined, a same-edge WB write to rs/rt is
//                           forwarded into ex_data_1/ex_data_2.
// ---------------------------------------------------------------------------
module id_ex_latch #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned BCNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_data_1,
   input  logic [DATA_W-1:0] id_data_2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [4:0]        id_shamt,
   input  logic [5:0]        id_funct,
   input  logic [9:0]        id_ctrl,
   input  logic [REG_AW-1:0] wb_reg_addr,
   input  logic [DATA_W-1:0] wb_write_data,
   input  logic              wb_write_enable,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_data_1,
   output logic [DATA_W-1:0] ex_data_2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [4:0]        ex_shamt,
   output logic [5:0]        ex_funct,
   output logic [9:0]        ex_ctrl,
   output logic              ex_valid,
   input  logic [2:0]        du_sel,
   output logic [DATA_W-1:0] du_data
);

   logic [DATA_W-1:0] pc4_q, pc4_d;
   logic [DATA_W-1:0] data_1_q, data_1_d;
   logic [DATA_W-1:0] data_2_q, data_2_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [REG_AW-1:0] rs_q, rs_d;
   logic [REG_AW-1:0] rt_q, rt_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [4:0]        shamt_q, shamt_d;
   logic [5:0]        funct_q, funct_d;
   logic [9:0]        ctrl_q, ctrl_d;
   logic              valid_q, valid_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;

   logic              bubble;
   logic [DATA_W-1:0] src_1;
   logic [DATA_W-1:0] src_2;

   assign bubble = stall | flush;

`ifdef ID_EX_WB_BYPASS_EN
   // Register file writes on the same edge we sample its combinational read,
   // so a matching WB write would otherwise be missed.
   logic wb_hit_1;
   logic wb_hit_2;
   assign wb_hit_1 = wb_write_enable && (wb_reg_addr != '0) && (wb_reg_addr == id_rs);
   assign wb_hit_2 = wb_write_enable && (wb_reg_addr != '0) && (wb_reg_addr == id_rt);
   assign src_1    = wb_hit_1 ? wb_write_data : id_data_1;
   assign src_2    = wb_hit_2 ? wb_write_data : id_data_2;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_reg_addr, wb_write_data, wb_write_enable};
   assign src_1     = id_data_1;
   assign src_2     = id_data_2;
`endif

   always_comb begin
      pc4_d    = pc4_q;
      data_1_d = data_1_q;
      data_2_d = data_2_q;
      imm_d    = imm_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      shamt_d  = shamt_q;
      funct_d  = funct_q;
      ctrl_d   = ctrl_q;
      valid_d  = valid_q;
      bcnt_d   = bcnt_q;
      if (!halt) begin
         // Data and specifier fields load even on a bubble so they stay visible.
         pc4_d    = id_pc4;
         data_1_d = src_1;
         data_2_d = src_2;
         imm_d    = id_imm;
         rs_d     = id_rs;
         rt_d     = id_rt;
         rd_d     = id_rd;
         shamt_d  = id_shamt;
         funct_d  = id_funct;
         if (bubble) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
            if (bcnt_q != {BCNT_W{1'b1}}) begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end else begin
            ctrl_d  = id_ctrl;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc4_q    <= '0;
         data_1_q <= '0;
         data_2_q <= '0;
         imm_q    <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         shamt_q  <= '0;
         funct_q  <= '0;
         ctrl_q   <= '0;
         valid_q  <= 1'b0;
         bcnt_q   <= '0;
      end else begin
         pc4_q    <= pc4_d;
         data_1_q <= data_1_d;
         data_2_q <= data_2_d;
         imm_q    <= imm_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         shamt_q  <= shamt_d;
         funct_q  <= funct_d;
         ctrl_q   <= ctrl_d;
         valid_q  <= valid_d;
         bcnt_q   <= bcnt_d;
      end
   end

   assign ex_pc4    = pc4_q;
   assign ex_data_1 = data_1_q;
   assign ex_data_2 = data_2_q;
   assign ex_imm    = imm_q;
   assign ex_rs     = rs_q;
   assign ex_rt     = rt_q;
   assign ex_rd     = rd_q;
   assign ex_shamt  = shamt_q;
   assign ex_funct  = funct_q;
   assign ex_ctrl   = ctrl_q;
   assign ex_valid  = valid_q;

   always_comb begin
      du_data = '0;
      case (du_sel)
         3'd0: du_data = pc4_q;
         3'd1: du_data = data_1_q;
         3'd2: du_data = data_2_q;
         3'd3: du_data = imm_q;
         3'd4: du_data = {rs_q, rt_q, rd_q, shamt_q, funct_q,
                          {(DATA_W - 3 * REG_AW - 11){1'b0}}};
         3'd5: du_data = {{(DATA_W - 11){1'b0}}, valid_q, ctrl_q};
         3'd6: du_data = {{(DATA_W - BCNT_W){1'b0}}, bcnt_q};
         default: du_data = '0;
      endcase
   end

endmodule

// File: tb/tb_id_ex_latch.sv
module tb_id_ex_latch;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt, stall, flush;
   logic [31:0] id_pc4, id_data_1, id_data_2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [5:0]  id_funct;
   logic [9:0]  id_ctrl;
   logic [4:0]  wb_reg_addr;
   logic [31:0] wb_write_data;
   logic        wb_write_enable;
   logic [31:0] ex_pc4, ex_data_1, ex_data_2, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [5:0]  ex_funct;
   logic [9:0]  ex_ctrl;
   logic        ex_valid;
   logic [2:0]  du_sel;
   logic [31:0] du_data;

   int errors = 0;
   int checks = 0;

   // Reference model state: what EX should hold, plus bubble count as an int.
   logic [31:0] m_pc4, m_d1, m_d2, m_imm;
   logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
   logic [5:0]  m_funct;
   logic [9:0]  m_ctrl;
   logic        m_valid;
   int          m_cnt;

   logic [31:0] bypass_exp;

   always #10 clk = ~clk;

   id_ex_latch dut (
      .clk(clk), .reset(reset), .halt(halt), .stall(stall), .flush(flush),
      .id_pc4(id_pc4), .id_data_1(id_data_1), .id_data_2(id_data_2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_funct(id_funct), .id_ctrl(id_ctrl),
      .wb_reg_addr(wb_reg_addr), .wb_write_data(wb_write_data),
      .wb_write_enable(wb_write_enable),
      .ex_pc4(ex_pc4), .ex_data_1(ex_data_1), .ex_data_2(ex_data_2), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
      .ex_funct(ex_funct), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
      .du_sel(du_sel), .du_data(du_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc4 = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_shamt = 0; m_funct = 0;
      m_ctrl = 0; m_valid = 0; m_cnt = 0;
   endtask

   // Applies the latch rules to the inputs present at the clock edge.
   task automatic model_edge();
      if (reset) begin
         model_reset();
      end else if (!halt) begin
         m_pc4 = id_pc4; m_d1 = id_data_1; m_d2 = id_data_2; m_imm = id_imm;
         m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_shamt = id_shamt; m_funct = id_funct;
`ifdef ID_EX_WB_BYPASS_EN
         if (wb_write_enable && wb_reg_addr != 0 && wb_reg_addr == id_rs) m_d1 = wb_write_data;
         if (wb_write_enable && wb_reg_addr != 0 && wb_reg_addr == id_rt) m_d2 = wb_write_data;
`endif
         if (stall || flush) begin
            m_ctrl = 0;
            m_valid = 0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
         end else begin
            m_ctrl = id_ctrl;
            m_valid = 1;
         end
      end
   endtask

   function automatic logic [31:0] du_exp(input int sel);
      case (sel)
         0: return m_pc4;
         1: return m_d1;
         2: return m_d2;
         3: return m_imm;
         4: return (32'(m_rs) << 27) | (32'(m_rt) << 22) | (32'(m_rd) << 17) |
                   (32'(m_shamt) << 12) | (32'(m_funct) << 6);
         5: return (32'(m_valid) << 10) | 32'(m_ctrl);
         6: return 32'(m_cnt);
         default: return 32'h0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_all();
      chk("ex_pc4", ex_pc4, m_pc4);
      chk("ex_data_1", ex_data_1, m_d1);
      chk("ex_data_2", ex_data_2, m_d2);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rs", 32'(ex_rs), 32'(m_rs));
      chk("ex_rt", 32'(ex_rt), 32'(m_rt));
      chk("ex_rd", 32'(ex_rd), 32'(m_rd));
      chk("ex_shamt", 32'(ex_shamt), 32'(m_shamt));
      chk("ex_funct", 32'(ex_funct), 32'(m_funct));
      chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      for (int s = 0; s < 8; s++) begin
         du_sel = 3'(s);
         #1;
         chk($sformatf("du_sel%0d", s), du_data, du_exp(s));
      end
   endtask

   task automatic rand_inputs();
      id_pc4 = $urandom; id_data_1 = $urandom; id_data_2 = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
      id_shamt = 5'($urandom); id_funct = 6'($urandom); id_ctrl = 10'($urandom);
      wb_write_data = $urandom;
      wb_write_enable = 1'($urandom);
      case ($urandom_range(0, 3))
         0: wb_reg_addr = id_rs;
         1: wb_reg_addr = id_rt;
         2: wb_reg_addr = 5'd0;
         default: wb_reg_addr = 5'($urandom);
      endcase
   endtask

   initial begin
      reset = 1; halt = 0; stall = 0; flush = 0; du_sel = 0;
      rand_inputs();
      wb_write_enable = 0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      reset = 0;

      // Normal load with known values.
      id_pc4 = 32'h10; id_data_1 = 32'h11; id_data_2 = 32'h22; id_ctrl = 10'h2A5;
      tick();
      check_all();
      du_sel = 3'd5; #1;
      chk("ctrl_readout", du_data, 32'h6A5);
      chk("valid_after_load", 32'(ex_valid), 32'd1);

      // Stall, flush, then both: one bubble each.
      rand_inputs(); stall = 1; flush = 0;
      tick(); check_all();
      du_sel = 3'd6; #1; chk("bcnt_after_stall", du_data, 32'd1);
      rand_inputs(); stall = 0; flush = 1;
      tick(); check_all();
      du_sel = 3'd6; #1; chk("bcnt_after_flush", du_data, 32'd2);
      rand_inputs(); stall = 1; flush = 1;
      tick(); check_all();
      du_sel = 3'd6; #1; chk("bcnt_after_both", du_data, 32'd3);
      chk("ctrl_bubble", 32'(ex_ctrl), 32'd0);

      // Halt overrides stall and flush.
      rand_inputs(); halt = 0; stall = 0; flush = 0;
      tick(); check_all();
      halt = 1; stall = 1; flush = 1;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         tick(); check_all();
      end
      halt = 0; stall = 0; flush = 0;
      rand_inputs();
      tick(); check_all();
      chk("valid_after_halt", 32'(ex_valid), 32'd1);

      // WB bypass into data_1.
      rand_inputs();
      id_rs = 5'd5; id_rt = 5'd6; id_data_1 = 32'hAAAA;
      wb_write_enable = 1; wb_reg_addr = 5'd5; wb_write_data = 32'h1234;
`ifdef ID_EX_WB_BYPASS_EN
      bypass_exp = 32'h1234;
`else
      bypass_exp = 32'hAAAA;
`endif
      tick(); check_all();
      chk("bypass_rs5", ex_data_1, bypass_exp);
      wb_reg_addr = 5'd0; id_rs = 5'd0;
      tick(); check_all();
      chk("bypass_r0", ex_data_1, 32'hAAAA);

      // Randomized mix of load / bubble / halt.
      for (int i = 0; i < 200; i++) begin
         rand_inputs();
         halt  = ($urandom_range(0, 7) == 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 4) == 0);
         tick(); check_all();
      end
      halt = 0; stall = 0; flush = 0;

      // Asynchronous reset between edges.
      rand_inputs();
      tick();
      #4;
      reset = 1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 0;

      // Counter saturation.
      stall = 1;
      for (int i = 0; i < 65537; i++) begin
         rand_inputs();
         tick();
      end
      check_all();
      du_sel = 3'd6; #1; chk("bcnt_saturated", du_data, 32'h0000FFFF);
      rand_inputs();
      tick();
      du_sel = 3'd6; #1; chk("bcnt_holds", du_data, 32'h0000FFFF);
      stall = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
